ccc_lock_reset_sequencer: RTL

- Supervises the fabric CCC/PLL: pulses the PLL asynchronous reset, waits for LOCK, debounces it, then releases downstream fabric resets (I2C core, APB glue, user logic) in ordered stages.
- Sits beside the CCC in the top-level SmartDesign.
- Clocked from a free-running clock, not GL0, so it stays alive while the PLL is unlocked.
- Re-asserts all stage resets on loss of lock; declares FAULT after repeated lock timeouts.

---
 rtl/ccc_seq_pkg.sv | 29 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/ccc_lock_reset_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/ccc_seq_pkg.sv
// Shared types and sizing helpers for the CCC lock / reset sequencer.
// Holds the FSM state encoding and the timer width calculation.
package ccc_seq_pkg;

    typedef enum logic [2:0] {
        StPllRst,
        StWaitLock,
        StDebounce,
        StRelease,
        StRun,
        StFault
    } seq_state_e;

    localparam int unsigned RetryW = 4;

    // Width of the shared timer: must hold every terminal count used by any state.
    function automatic int unsigned timer_width(input int unsigned arst_cycles,
                                                input int unsigned lock_timeout,
                                                input int unsigned lock_stable,
                                                input int unsigned release_span);
        int unsigned m;
        m = arst_cycles;
        if (lock_timeout > m) m = lock_timeout;
        if (lock_stable > m) m = lock_stable;
        if (release_span > m) m = release_span;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for bringing asynchronous levels into a clock domain.
module sync_2ff #(
    parameter int unsigned     WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/ccc_lock_reset_sequencer.sv
// Supervises the CCC PLL: pulses its reset, waits for a debounced LOCK, then releases
// downstream fabric resets in ordered stages; re-asserts them all on loss of lock.
module ccc_lock_reset_sequencer
    import ccc_seq_pkg::*;
#(
    parameter int unsigned ARST_CYCLES  = 16,
    parameter int unsigned LOCK_TIMEOUT = 4096,
    parameter int unsigned LOCK_STABLE  = 256,
    parameter int unsigned NUM_STAGES   = 3,
    parameter int unsigned STAGE_GAP    = 32,
    parameter int unsigned MAX_RETRIES  = 3,
    parameter int unsigned CNT_W        = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_lock,
    input  logic                  i_sw_reset_req,
    output logic                  o_pll_arst_n,
    output logic [NUM_STAGES-1:0] o_stage_rst,
    output logic                  o_ready,
    output logic                  o_fault,
    output logic [RetryW-1:0]     o_retry_cnt,
    output logic [CNT_W-1:0]      o_loss_cnt
);

    localparam int unsigned TW = timer_width(ARST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE,
                                             NUM_STAGES * STAGE_GAP);
    localparam logic [TW-1:0] ArstLast    = TW'(ARST_CYCLES - 1);
    localparam logic [TW-1:0] TimeoutLast = TW'(LOCK_TIMEOUT - 1);
    // The WAIT_LOCK cycle that first sees lock_s counts as the first stable cycle.
    localparam logic [TW-1:0] StableLast  = TW'((LOCK_STABLE > 1) ? LOCK_STABLE - 2 : 0);
    localparam logic [TW-1:0] ReleaseLast = TW'((NUM_STAGES - 1) * STAGE_GAP);
    localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRIES);

    seq_state_e              r_state, w_state_d;
    logic [TW-1:0]           r_timer, w_timer_d;
    logic [RetryW-1:0]       r_retry, w_retry_d;
    logic [CNT_W-1:0]        r_loss, w_loss_d;
    logic                    w_lock_s;
    logic                    r_pll_arst_n, w_pll_arst_n_d;
    logic [NUM_STAGES-1:0]   r_stage_rst, w_stage_rst_d;
    logic                    r_ready, w_ready_d;
    logic                    r_fault, w_fault_d;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b0)
    ) u_lock_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_lock),
        .o_q   (w_lock_s)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StPllRst;
            r_timer <= '0;
            r_retry <= '0;
            r_loss  <= '0;
        end else begin
            r_state <= w_state_d;
            r_timer <= w_timer_d;
            r_retry <= w_retry_d;
            r_loss  <= w_loss_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_retry_d = r_retry;
        w_loss_d  = r_loss;
        if (i_sw_reset_req) begin
            w_state_d = StPllRst;
            w_retry_d = '0;
        end else begin
            unique case (r_state)
                StPllRst: begin
                    if (r_timer == '0 && r_retry != '1) w_retry_d = r_retry + 1'b1;
                    if (r_timer == ArstLast) w_state_d = StWaitLock;
                end
                StWaitLock: begin
                    if (w_lock_s) begin
                        w_state_d = (LOCK_STABLE > 1) ? StDebounce : StRelease;
                    end else if (r_timer == TimeoutLast) begin
                        w_state_d = (r_retry >= RetryMax) ? StFault : StPllRst;
                    end
                end
                StDebounce: begin
                    if (!w_lock_s) w_state_d = StWaitLock;
                    else if (r_timer == StableLast) w_state_d = StRelease;
                end
                StRelease: begin
                    if (!w_lock_s) w_state_d = StWaitLock;
                    else if (r_timer == ReleaseLast) w_state_d = StRun;
                end
                StRun: begin
                    if (!w_lock_s) begin
                        w_state_d = StWaitLock;
                        w_retry_d = '0;
                        if (r_loss != '1) w_loss_d = r_loss + 1'b1;
                    end
                end
                StFault: w_state_d = StFault;
                default: w_state_d = StPllRst;
            endcase
        end
        // Timer restarts on every state entry, including a software re-entry of PLL_RST.
        w_timer_d = (w_state_d != r_state || i_sw_reset_req) ? '0 : r_timer + 1'b1;
    end

    // Outputs are decoded from next state so the registered copies line up with r_state.
    always_comb begin
        w_pll_arst_n_d = !(w_state_d == StPllRst || w_state_d == StFault);
        w_ready_d      = (w_state_d == StRun);
        w_fault_d      = (w_state_d == StFault);
        w_stage_rst_d  = '1;
        if (w_state_d == StRun) begin
            w_stage_rst_d = '0;
        end else if (w_state_d == StRelease) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                if (w_timer_d >= TW'(k * STAGE_GAP)) w_stage_rst_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pll_arst_n <= 1'b0;
            r_stage_rst  <= '1;
            r_ready      <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_pll_arst_n <= w_pll_arst_n_d;
            r_stage_rst  <= w_stage_rst_d;
            r_ready      <= w_ready_d;
            r_fault      <= w_fault_d;
        end
    end

    assign o_pll_arst_n = r_pll_arst_n;
    assign o_stage_rst  = r_stage_rst;
    assign o_ready      = r_ready;
    assign o_fault      = r_fault;
    assign o_retry_cnt  = r_retry;
    assign o_loss_cnt   = r_loss;

endmodule
